// File: rtl/shared_buffer_ram_ctrl_pkg.sv
// Shared definitions for the shared-buffer cell store: default geometry
// and the controller state encoding.
package shared_buffer_pkg;

    localparam int DEF_ADDR_BITWIDTH = 13;
    localparam int DEF_DATA_BITWIDTH = 86;  // 72 payload + 13 next-pointer + 1 last-flag

    typedef enum logic {
        ST_INIT = 1'b0,  // sweeping INIT_VALUE through every address
        ST_RUN  = 1'b1   // user traffic accepted
    } state_e;

endpackage

// File: rtl/shared_buffer_ram_ctrl_if.sv
// Access bus between the buffer manager (master) and the cell store (slave).
interface shared_buffer_ram_ctrl_if
    import shared_buffer_pkg::*;
#(
    parameter int ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
    parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
    parameter int NUM_LANES     = 2
);
    logic                     rd_en;
    logic [ADDR_BITWIDTH-1:0] r_addr;
    logic                     wr_en;
    logic [NUM_LANES-1:0]     w_lane_en;
    logic [ADDR_BITWIDTH-1:0] w_addr;
    logic [DATA_BITWIDTH-1:0] w_data;
    logic [DATA_BITWIDTH-1:0] r_data;
    logic                     r_valid;
    logic                     init_done;

    modport master (
        output rd_en, r_addr, wr_en, w_lane_en, w_addr, w_data,
        input  r_data, r_valid, init_done
    );

    modport slave (
        input  rd_en, r_addr, wr_en, w_lane_en, w_addr, w_data,
        output r_data, r_valid, init_done
    );
endinterface

// File: rtl/shared_buffer_ram_core.sv
// Plain simple-dual-port storage array: one lane-masked write port and one
// registered read port. No reset so it maps onto block RAM. A read of the
// address being written in the same cycle returns the old word.
module shared_buffer_ram_core #(
    parameter int ADDR_BITWIDTH = 13,
    parameter int DATA_BITWIDTH = 86,
    parameter int NUM_LANES     = 2
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [NUM_LANES-1:0]     lane_en_i,
    input  logic [ADDR_BITWIDTH-1:0] w_addr_i,
    input  logic [DATA_BITWIDTH-1:0] w_data_i,
    input  logic                     rd_en_i,
    input  logic [ADDR_BITWIDTH-1:0] r_addr_i,
    output logic [DATA_BITWIDTH-1:0] r_data_o
);
    localparam int DEPTH = 2 ** ADDR_BITWIDTH;
    localparam int LW    = DATA_BITWIDTH / NUM_LANES;

    logic [DATA_BITWIDTH-1:0] mem [DEPTH];
    logic [DATA_BITWIDTH-1:0] r_data_q;

    // Lane-masked write and registered read; read output holds when idle.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int li = 0; li < NUM_LANES; li++) begin
                if (lane_en_i[li]) begin
                    mem[w_addr_i][li*LW +: LW] <= w_data_i[li*LW +: LW];
                end
            end
        end
        if (rd_en_i) begin
            r_data_q <= mem[r_addr_i];
        end
    end

    assign r_data_o = r_data_q;
endmodule

// File: rtl/shared_buffer_ram_ctrl.sv
// Shared-buffer cell store controller: init sweep after reset, user write
// mux, same-cycle write-to-read forwarding and optional output register.
module shared_buffer_ram_ctrl
    import shared_buffer_pkg::*;
#(
    parameter int                            ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
    parameter int                            DATA_BITWIDTH = DEF_DATA_BITWIDTH,
    parameter int                            NUM_LANES     = 2,
    parameter int                            OUT_REG       = 0,
    parameter logic [DATA_BITWIDTH-1:0]      INIT_VALUE    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    shared_buffer_ram_ctrl_if.slave  bus
);
    localparam int                       LW        = DATA_BITWIDTH / NUM_LANES;
    localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = '1;

    state_e                   state_q, state_d;
    logic [ADDR_BITWIDTH-1:0] cnt_q, cnt_d;

    logic                     ram_we;
    logic [NUM_LANES-1:0]     ram_lane_en;
    logic [ADDR_BITWIDTH-1:0] ram_w_addr;
    logic [DATA_BITWIDTH-1:0] ram_w_data;
    logic [DATA_BITWIDTH-1:0] ram_r_data;

    logic                     rd_fire;
    logic                     coll_d;
    logic                     s1_valid_q;
    logic                     coll_q;
    logic [NUM_LANES-1:0]     mask_q;
    logic [DATA_BITWIDTH-1:0] fwd_data_q;
    logic [DATA_BITWIDTH-1:0] merged;

    // Next state: walk the counter through every address, then run forever.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + ADDR_BITWIDTH'(1);
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    // State and init counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write port mux: the init sweep owns the port until it finishes.
    always_comb begin
        ram_we      = bus.wr_en && (|bus.w_lane_en);
        ram_lane_en = bus.w_lane_en;
        ram_w_addr  = bus.w_addr;
        ram_w_data  = bus.w_data;
        if (state_q == ST_INIT) begin
            ram_we      = 1'b1;
            ram_lane_en = '1;
            ram_w_addr  = cnt_q;
            ram_w_data  = INIT_VALUE;
        end
    end

    assign rd_fire = (state_q == ST_RUN) && bus.rd_en;
    assign coll_d  = rd_fire && bus.wr_en && (bus.r_addr == bus.w_addr);

    shared_buffer_ram_core #(
        .ADDR_BITWIDTH (ADDR_BITWIDTH),
        .DATA_BITWIDTH (DATA_BITWIDTH),
        .NUM_LANES     (NUM_LANES)
    ) u_core (
        .clk       (clk),
        .we_i      (ram_we),
        .lane_en_i (ram_lane_en),
        .w_addr_i  (ram_w_addr),
        .w_data_i  (ram_w_data),
        .rd_en_i   (rd_fire),
        .r_addr_i  (bus.r_addr),
        .r_data_o  (ram_r_data)
    );

    // Capture read-issue info alongside the RAM read so forwarding lines up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            coll_q     <= 1'b0;
            mask_q     <= '0;
            fwd_data_q <= '0;
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) begin
                coll_q     <= coll_d;
                mask_q     <= bus.w_lane_en;
                fwd_data_q <= bus.w_data;
            end
        end
    end

    // Per-lane merge: colliding lanes take the write data, others the old word.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign merged[gi*LW +: LW] = (coll_q && mask_q[gi]) ? fwd_data_q[gi*LW +: LW]
                                                             : ram_r_data[gi*LW +: LW];
    end

    if (OUT_REG == 0) begin : g_direct
        logic seen_read_q;

        // Remember whether any read completed since reset so r_data reads 0 until then.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                seen_read_q <= 1'b0;
            end else if (rd_fire) begin
                seen_read_q <= 1'b1;
            end
        end

        assign bus.r_data  = seen_read_q ? merged : '0;
        assign bus.r_valid = s1_valid_q;
    end else begin : g_outreg
        logic [DATA_BITWIDTH-1:0] r_data_q;
        logic                     r_valid_q;

        // Extra output stage; data holds between reads.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b0;
            end else begin
                r_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    r_data_q <= merged;
                end
            end
        end

        assign bus.r_data  = r_data_q;
        assign bus.r_valid = r_valid_q;
    end

    assign bus.init_done = (state_q == ST_RUN);
endmodule

// File: tb/tb_shared_buffer_ram_ctrl.sv
// Directed bench: two controllers (latency 1 and latency 2) driven with the
// same stimulus, compared against hand-computed expectations.
module tb_shared_buffer_ram_ctrl;
    localparam int AW = 4;
    localparam int DW = 86;
    localparam int NL = 2;

    localparam logic [DW-1:0] IV    = 86'h2A_BCDE_0000_0000_1357;
    localparam logic [DW-1:0] ALL1  = {86{1'b1}};
    localparam logic [DW-1:0] UP1   = {{43{1'b1}}, {43{1'b0}}};
    localparam logic [DW-1:0] WUP   = 86'h800_0000_0022;
    localparam logic [DW-1:0] MIX   = 86'h800_0000_0011;

    typedef struct {
        logic          rd;
        logic [AW-1:0] ra;
        logic          wr;
        logic [NL-1:0] le;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          ev;
        logic [DW-1:0] ed;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] r_addr;
    logic          wr_en;
    logic [NL-1:0] w_lane_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    int checks;
    int failures;
    logic [DW-1:0] exp_mem [16];
    vec_t vt [16];

    shared_buffer_ram_ctrl_if #(.ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW), .NUM_LANES(NL)) bus0 ();
    shared_buffer_ram_ctrl_if #(.ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW), .NUM_LANES(NL)) bus1 ();

    assign bus0.rd_en     = rd_en;
    assign bus0.r_addr    = r_addr;
    assign bus0.wr_en     = wr_en;
    assign bus0.w_lane_en = w_lane_en;
    assign bus0.w_addr    = w_addr;
    assign bus0.w_data    = w_data;
    assign bus1.rd_en     = rd_en;
    assign bus1.r_addr    = r_addr;
    assign bus1.wr_en     = wr_en;
    assign bus1.w_lane_en = w_lane_en;
    assign bus1.w_addr    = w_addr;
    assign bus1.w_data    = w_data;

    shared_buffer_ram_ctrl #(
        .ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW), .NUM_LANES(NL),
        .OUT_REG(0), .INIT_VALUE(IV)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    shared_buffer_ram_ctrl #(
        .ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW), .NUM_LANES(NL),
        .OUT_REG(1), .INIT_VALUE(IV)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic chk_word(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Called at the negedge where rst_n was just released; rd/wr stay high.
    task automatic init_sweep(input string tag);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk_bit({tag, "_done0"}, bus0.init_done, k == 16);
            chk_bit({tag, "_done1"}, bus1.init_done, k == 16);
            chk_bit({tag, "_valid0"}, bus0.r_valid, 1'b0);
            chk_bit({tag, "_valid1"}, bus1.r_valid, 1'b0);
        end
        $display("%s: init sweep of 16 cycles observed, init_done=%b/%b", tag, bus0.init_done, bus1.init_done);
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    // Back-to-back reads of addresses 0..n-1 against exp_mem.
    task automatic read_burst(input int n, input string tag);
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                rd_en  = 1'b1;
                r_addr = AW'(i);
            end else begin
                rd_en = 1'b0;
            end
            @(negedge clk);
            chk_bit({tag, "_valid0"}, bus0.r_valid, i < n);
            if (i < n) chk_word({tag, "_data0"}, bus0.r_data, exp_mem[i]);
            chk_bit({tag, "_valid1"}, bus1.r_valid, (i >= 1) && (i <= n));
            if ((i >= 1) && (i <= n)) chk_word({tag, "_data1"}, bus1.r_data, exp_mem[i-1]);
            $display("%s step %0d: v0=%b d0=%h v1=%b d1=%h", tag, i, bus0.r_valid, bus0.r_data, bus1.r_valid, bus1.r_data);
        end
    endtask

    initial begin
        logic          prev_ev;
        logic [DW-1:0] prev_ed;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        rd_en     = 1'b1;
        r_addr    = '0;
        wr_en     = 1'b1;
        w_lane_en = 2'b11;
        w_addr    = 4'd2;
        w_data    = 86'hDEAD;

        vt[0]  = '{1'b0, 4'd0, 1'b1, 2'b11, 4'd3, 86'h2A5, 1'b0, 86'h0};
        vt[1]  = '{1'b1, 4'd3, 1'b0, 2'b00, 4'd0, 86'h0,   1'b1, 86'h2A5};
        vt[2]  = '{1'b0, 4'd0, 1'b1, 2'b11, 4'd5, ALL1,    1'b0, 86'h0};
        vt[3]  = '{1'b0, 4'd0, 1'b1, 2'b01, 4'd5, 86'h0,   1'b0, 86'h0};
        vt[4]  = '{1'b1, 4'd5, 1'b0, 2'b00, 4'd0, 86'h0,   1'b1, UP1};
        vt[5]  = '{1'b0, 4'd0, 1'b1, 2'b11, 4'd7, 86'h11,  1'b0, 86'h0};
        vt[6]  = '{1'b1, 4'd7, 1'b1, 2'b11, 4'd7, 86'h22,  1'b1, 86'h22};
        vt[7]  = '{1'b0, 4'd0, 1'b1, 2'b11, 4'd7, 86'h11,  1'b0, 86'h0};
        vt[8]  = '{1'b1, 4'd7, 1'b1, 2'b10, 4'd7, WUP,     1'b1, MIX};
        vt[9]  = '{1'b1, 4'd7, 1'b0, 2'b00, 4'd0, 86'h0,   1'b1, MIX};
        vt[10] = '{1'b1, 4'd5, 1'b1, 2'b00, 4'd5, 86'h0,   1'b1, UP1};
        vt[11] = '{1'b1, 4'd5, 1'b0, 2'b00, 4'd0, 86'h0,   1'b1, UP1};
        vt[12] = '{1'b1, 4'd9, 1'b0, 2'b00, 4'd0, 86'h0,   1'b1, IV};
        vt[13] = '{1'b1, 4'd3, 1'b1, 2'b11, 4'd4, 86'h77,  1'b1, 86'h2A5};
        vt[14] = '{1'b1, 4'd4, 1'b0, 2'b00, 4'd0, 86'h0,   1'b1, 86'h77};
        vt[15] = '{1'b0, 4'd0, 1'b0, 2'b00, 4'd0, 86'h0,   1'b0, 86'h0};

        // Reset values, then the init sweep with user requests held high.
        repeat (2) @(negedge clk);
        chk_bit("rst_done0", bus0.init_done, 1'b0);
        chk_bit("rst_valid0", bus0.r_valid, 1'b0);
        chk_word("rst_data0", bus0.r_data, '0);
        chk_bit("rst_done1", bus1.init_done, 1'b0);
        chk_bit("rst_valid1", bus1.r_valid, 1'b0);
        chk_word("rst_data1", bus1.r_data, '0);
        rst_n = 1'b1;
        init_sweep("init");

        for (int i = 0; i < 16; i++) exp_mem[i] = IV;
        read_burst(16, "sweep");

        // Table of single-cycle operations.
        prev_ev = 1'b0;
        prev_ed = '0;
        for (int i = 0; i < 16; i++) begin
            rd_en     = vt[i].rd;
            r_addr    = vt[i].ra;
            wr_en     = vt[i].wr;
            w_lane_en = vt[i].le;
            w_addr    = vt[i].wa;
            w_data    = vt[i].wd;
            @(negedge clk);
            chk_bit($sformatf("vec%0d_valid0", i), bus0.r_valid, vt[i].ev);
            if (vt[i].ev) chk_word($sformatf("vec%0d_data0", i), bus0.r_data, vt[i].ed);
            chk_bit($sformatf("vec%0d_valid1", i), bus1.r_valid, prev_ev);
            if (prev_ev) chk_word($sformatf("vec%0d_data1", i), bus1.r_data, prev_ed);
            $display("vec %0d: rd=%b ra=%0d wr=%b le=%b wa=%0d v0=%b d0=%h v1=%b d1=%h",
                     i, vt[i].rd, vt[i].ra, vt[i].wr, vt[i].le, vt[i].wa,
                     bus0.r_valid, bus0.r_data, bus1.r_valid, bus1.r_data);
            prev_ev = vt[i].ev;
            prev_ed = vt[i].ed;
        end
        @(negedge clk);
        chk_word("hold_data0", bus0.r_data, 86'h77);
        chk_word("hold_data1", bus1.r_data, 86'h77);

        // Fill 0..7 with distinct words and read them back to back.
        for (int i = 0; i < 8; i++) begin
            wr_en     = 1'b1;
            w_lane_en = 2'b11;
            w_addr    = AW'(i);
            w_data    = 86'h100 + DW'(i);
            exp_mem[i] = 86'h100 + DW'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        read_burst(8, "b2b");

        // Reset in the middle of a read burst.
        for (int i = 0; i < 4; i++) begin
            rd_en  = 1'b1;
            r_addr = AW'(i);
            @(negedge clk);
        end
        chk_word("pre_rst_data0", bus0.r_data, 86'h103);
        rst_n = 1'b0;
        #1;
        chk_bit("midrst_valid0", bus0.r_valid, 1'b0);
        chk_word("midrst_data0", bus0.r_data, '0);
        chk_bit("midrst_done0", bus0.init_done, 1'b0);
        chk_bit("midrst_valid1", bus1.r_valid, 1'b0);
        chk_word("midrst_data1", bus1.r_data, '0);
        chk_bit("midrst_done1", bus1.init_done, 1'b0);
        $display("mid-burst reset: v0=%b d0=%h done0=%b", bus0.r_valid, bus0.r_data, bus0.init_done);
        wr_en     = 1'b1;
        w_lane_en = 2'b11;
        w_addr    = 4'd1;
        w_data    = 86'hBAD;
        @(negedge clk);
        rst_n = 1'b1;
        init_sweep("reinit");

        for (int i = 0; i < 16; i++) exp_mem[i] = IV;
        read_burst(16, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
